// File: rtl/dcache_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dcache_pkg -- D-cache tag-word layout, maintenance FSM encoding, field helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package dcache_pkg;

   localparam int IDX_W     = 9;
   localparam int TAG_W     = 16;
   localparam int WAY_W     = 18;
   localparam int VALID_BIT = 17;
   localparam int DIRTY_BIT = 16;

   typedef logic [WAY_W-1:0] way_t;

   // Maintenance FSM state encoding
   typedef logic [2:0] maint_state_t;
   localparam maint_state_t ST_IDLE = 3'd0;
   localparam maint_state_t ST_RD   = 3'd1;
   localparam maint_state_t ST_CHK  = 3'd2;
   localparam maint_state_t ST_WBA  = 3'd3;
   localparam maint_state_t ST_WBB  = 3'd4;
   localparam maint_state_t ST_UPD  = 3'd5;
   localparam maint_state_t ST_NXT  = 3'd6;

   function automatic logic way_valid(input way_t w);
      return w[VALID_BIT];
   endfunction

   function automatic logic way_dirty(input way_t w);
      return w[DIRTY_BIT];
   endfunction

   function automatic logic [TAG_W-1:0] way_tag(input way_t w);
      return w[TAG_W-1:0];
   endfunction

   // A line needs writeback only when it is both valid and dirty
   function automatic logic way_needs_wb(input way_t w);
      return way_valid(w) & way_dirty(w);
   endfunction

   function automatic way_t way_clean(input way_t w);
      way_t r;
      r            = w;
      r[DIRTY_BIT] = 1'b0;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_maint_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dcache_maint_engine -- walks the 2-way D-cache tag array, writes back dirty
// lines, then invalidates or cleans each set. Optional: DCACHE_MAINT_STATS_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module dcache_maint_engine #(
   parameter int IDX_W = dcache_pkg::IDX_W,
   parameter int TAG_W = dcache_pkg::TAG_W,
   parameter int WAY_W = dcache_pkg::WAY_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   input  logic                 cmd_inv,
   input  logic                 cmd_all,
   input  logic [IDX_W-1:0]     cmd_index,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           tag_we,
   output logic [IDX_W-1:0]     tag_addr,
   output logic [2*WAY_W-1:0]   tag_din,
   input  logic [2*WAY_W-1:0]   tag_dout,
   output logic                 wb_req,
   output logic                 wb_way,
   output logic [IDX_W-1:0]     wb_index,
   output logic [TAG_W-1:0]     wb_tag,
`ifdef DCACHE_MAINT_STATS_EN
   output logic [IDX_W+1:0]     wb_count,
`endif
   input  logic                 wb_ack
);
   import dcache_pkg::*;

   maint_state_t          r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [2*WAY_W-1:0]    r_entry;
   logic                  r_inv;
   logic                  r_all;
   logic                  r_done;

   logic [WAY_W-1:0]      w_ent_a;
   logic [WAY_W-1:0]      w_ent_b;
   logic                  w_wb_a;
   logic                  w_wb_b;
   logic                  w_chk_a;
   logic                  w_chk_b;
   logic                  w_last;

   assign w_ent_a = r_entry[WAY_W-1:0];
   assign w_ent_b = r_entry[2*WAY_W-1:WAY_W];
   assign w_wb_a  = way_needs_wb(w_ent_a);
   assign w_wb_b  = way_needs_wb(w_ent_b);
   // CHK decides from the live RAM output, in parallel with capturing it
   assign w_chk_a = way_needs_wb(tag_dout[WAY_W-1:0]);
   assign w_chk_b = way_needs_wb(tag_dout[2*WAY_W-1:WAY_W]);
   assign w_last  = !r_all || (r_idx == {IDX_W{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_entry <= '0;
         r_inv   <= 1'b0;
         r_all   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_inv   <= cmd_inv;
                  r_all   <= cmd_all;
                  r_idx   <= cmd_all ? '0 : cmd_index;
                  r_state <= ST_RD;
               end
            end
            ST_RD:  r_state <= ST_CHK;
            ST_CHK: begin
               r_entry <= tag_dout;
               if (w_chk_a)      r_state <= ST_WBA;
               else if (w_chk_b) r_state <= ST_WBB;
               else              r_state <= ST_UPD;
            end
            ST_WBA: begin
               if (wb_ack) r_state <= w_wb_b ? ST_WBB : ST_UPD;
            end
            ST_WBB: begin
               if (wb_ack) r_state <= ST_UPD;
            end
            ST_UPD: r_state <= ST_NXT;
            ST_NXT: begin
               if (w_last) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= ST_RD;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode from state so an asynchronous reset silences them at once
   always_comb begin
      busy     = (r_state != ST_IDLE);
      done     = r_done;
      tag_addr = r_idx;
      tag_we   = 2'b00;
      tag_din  = '0;
      wb_req   = 1'b0;
      wb_way   = 1'b0;
      wb_index = '0;
      wb_tag   = '0;
      case (r_state)
         ST_WBA: begin
            wb_req   = 1'b1;
            wb_index = r_idx;
            wb_tag   = way_tag(w_ent_a);
         end
         ST_WBB: begin
            wb_req   = 1'b1;
            wb_way   = 1'b1;
            wb_index = r_idx;
            wb_tag   = way_tag(w_ent_b);
         end
         ST_UPD: begin
            if (r_inv) begin
               tag_we = 2'b11;
            end else begin
               tag_we  = {w_wb_b, w_wb_a};
               tag_din = {way_clean(w_ent_b), way_clean(w_ent_a)};
            end
         end
         default: ;
      endcase
   end

`ifdef DCACHE_MAINT_STATS_EN
   logic [IDX_W+1:0] r_wb_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_count <= '0;
      end else if ((r_state == ST_IDLE) && cmd_valid) begin
         r_wb_count <= '0;
      end else if (wb_req && wb_ack && (r_wb_count != {(IDX_W+2){1'b1}})) begin
         r_wb_count <= r_wb_count + 1'b1;
      end
   end

   assign wb_count = r_wb_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_maint_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dcache_maint_engine -- directed, table-driven bench with a tag RAM model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dcache_maint_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_inv = 1'b0;
   logic        cmd_all = 1'b0;
   logic [8:0]  cmd_index = '0;
   logic        busy;
   logic        done;
   logic [1:0]  tag_we;
   logic [8:0]  tag_addr;
   logic [35:0] tag_din;
   logic [35:0] tag_dout = '0;
   logic        wb_req;
   logic        wb_way;
   logic [8:0]  wb_index;
   logic [15:0] wb_tag;
   logic        wb_ack = 1'b0;
`ifdef DCACHE_MAINT_STATS_EN
   logic [10:0] wb_count;
`endif

   always #5 clk = ~clk;

   dcache_maint_engine dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_inv(cmd_inv), .cmd_all(cmd_all), .cmd_index(cmd_index),
      .busy(busy), .done(done),
      .tag_we(tag_we), .tag_addr(tag_addr), .tag_din(tag_din), .tag_dout(tag_dout),
      .wb_req(wb_req), .wb_way(wb_way), .wb_index(wb_index), .wb_tag(wb_tag),
`ifdef DCACHE_MAINT_STATS_EN
      .wb_count(wb_count),
`endif
      .wb_ack(wb_ack)
   );

   // Tag RAM model: synchronous read, per-way write, plus a bench back door
   logic [35:0] mem [512];
   logic        tb_clr = 1'b0;
   logic        tb_we = 1'b0;
   logic [8:0]  tb_addr = '0;
   logic [35:0] tb_data = '0;

   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < 512; i++) mem[i] <= '0;
      end else if (tb_we) begin
         mem[tb_addr] <= tb_data;
      end else begin
         if (tag_we[0]) mem[tag_addr][17:0]  <= tag_din[17:0];
         if (tag_we[1]) mem[tag_addr][35:18] <= tag_din[35:18];
      end
      tag_dout <= mem[tag_addr];
   end

   // Monitor and writeback responder
   int          ack_lat = 1;
   bit          noise_ack = 1'b0;
   int          busy_total = 0, done_total = 0, wr_total = 0, wr_inv_total = 0;
   int          wb_total = 0, hold_err = 0, req_cnt = 0;
   bit          new_req = 1'b1;
   logic [1:0]  last_we = '0;
   logic [35:0] last_din = '0;
   logic        h_way;
   logic [8:0]  h_idx;
   logic [15:0] h_tag;
   logic        log_way  [16];
   logic [8:0]  log_idx  [16];
   logic [15:0] log_tag  [16];
   int          log_hold [16];

   always @(negedge clk) begin
      if (busy) busy_total++;
      if (done) done_total++;
      if (tag_we != 2'b00) begin
         wr_total++;
         last_we  = tag_we;
         last_din = tag_din;
         if (tag_we == 2'b11 && tag_din == '0) wr_inv_total++;
      end
      if (wb_req) begin
         if (new_req) begin
            req_cnt = 1;
            h_way = wb_way; h_idx = wb_index; h_tag = wb_tag;
         end else begin
            req_cnt++;
            if (wb_way !== h_way || wb_index !== h_idx || wb_tag !== h_tag) hold_err++;
         end
         wb_ack  = (req_cnt >= ack_lat);
         new_req = wb_ack;
         if (wb_ack) begin
            log_way[wb_total % 16]  = wb_way;
            log_idx[wb_total % 16]  = wb_index;
            log_tag[wb_total % 16]  = wb_tag;
            log_hold[wb_total % 16] = req_cnt;
            wb_total++;
         end
      end else begin
         req_cnt = 0;
         new_req = 1'b1;
         wb_ack  = noise_ack;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [8:0] a, input logic [35:0] d);
      @(negedge clk); tb_we = 1'b1; tb_addr = a; tb_data = d;
      @(negedge clk); tb_we = 1'b0;
   endtask

   task automatic clear_mem();
      @(negedge clk); tb_clr = 1'b1;
      @(negedge clk); tb_clr = 1'b0;
   endtask

   task automatic issue(input bit inv, input bit all, input logic [8:0] idx);
      @(negedge clk); cmd_valid = 1'b1; cmd_inv = inv; cmd_all = all; cmd_index = idx;
      @(negedge clk); cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk); #1;
         if (done) seen = 1'b1;
      end
      if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   typedef struct {
      bit          inv;
      logic [8:0]  idx;
      logic [35:0] init;
      int          ack_lat;
      int          exp_nwb;
      int          exp_cycles;
      int          exp_wr;
      logic [1:0]  exp_we;
      logic [35:0] exp_din;
      logic [35:0] exp_mem;
      logic        exp_way0;
      logic [15:0] exp_tag0;
   } vec_t;

   vec_t vt [6];
   int b0, d0, w0, wi0, k0, h0;

   initial begin
      // inv idx init ack | nwb cycles wr we din mem way0 tag0
      vt[0] = '{1'b0, 9'h1A5, {18'h25678, 18'h31234}, 3, 1, 7, 1, 2'b01,
                {18'h25678, 18'h21234}, {18'h25678, 18'h21234}, 1'b0, 16'h1234};
      vt[1] = '{1'b1, 9'h003, {18'h3BBBB, 18'h2AAAA}, 1, 1, 5, 1, 2'b11,
                36'h0, 36'h0, 1'b1, 16'hBBBB};
      vt[2] = '{1'b0, 9'h100, {18'h3DDDD, 18'h1CCCC}, 2, 1, 6, 1, 2'b10,
                {18'h2DDDD, 18'h0CCCC}, {18'h2DDDD, 18'h1CCCC}, 1'b1, 16'hDDDD};
      vt[3] = '{1'b0, 9'h0FF, {18'h21111, 18'h2EEEE}, 1, 0, 4, 0, 2'b00,
                36'h0, {18'h21111, 18'h2EEEE}, 1'b0, 16'h0};
      vt[4] = '{1'b1, 9'h1FF, {18'h00000, 18'h10001}, 1, 0, 4, 1, 2'b11,
                36'h0, 36'h0, 1'b0, 16'h0};
      vt[5] = '{1'b0, 9'h010, {18'h30123, 18'h3ABCD}, 1, 2, 6, 1, 2'b11,
                {18'h20123, 18'h2ABCD}, {18'h20123, 18'h2ABCD}, 1'b0, 16'hABCD};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tag_we", tag_we, 0);
      chk("rst_tag_addr", tag_addr, 0);
      chk("rst_tag_din", tag_din, 0);
      chk("rst_wb_req", wb_req, 0);
      chk("rst_wb_way", wb_way, 0);
      chk("rst_wb_index", wb_index, 0);
      chk("rst_wb_tag", wb_tag, 0);
`ifdef DCACHE_MAINT_STATS_EN
      chk("rst_wb_count", wb_count, 0);
`endif
      rst = 1'b0;

      // INV whole cache, all entries zero
      clear_mem();
      @(negedge clk); #1;
      b0 = busy_total; d0 = done_total; w0 = wr_total; wi0 = wr_inv_total; k0 = wb_total;
      issue(1'b1, 1'b1, 9'h0);
      wait_done(2100, "invall");
      @(negedge clk); #1;
      chk("invall_cycles", busy_total - b0, 2048);
      chk("invall_writes", wr_total - w0, 512);
      chk("invall_zero_writes", wr_inv_total - wi0, 512);
      chk("invall_wbs", wb_total - k0, 0);
      chk("invall_done_pulses", done_total - d0, 1);
      chk("invall_busy_after", busy, 0);

      // Single-set vectors
      for (int i = 0; i < 6; i++) begin
         poke(vt[i].idx, vt[i].init);
         ack_lat = vt[i].ack_lat;
         @(negedge clk); #1;
         b0 = busy_total; d0 = done_total; w0 = wr_total; k0 = wb_total; h0 = hold_err;
         issue(vt[i].inv, 1'b0, vt[i].idx);
         wait_done(60, $sformatf("v%0d", i));
         @(negedge clk); #1;
         chk($sformatf("v%0d_cycles", i), busy_total - b0, vt[i].exp_cycles);
         chk($sformatf("v%0d_nwb", i), wb_total - k0, vt[i].exp_nwb);
         chk($sformatf("v%0d_writes", i), wr_total - w0, vt[i].exp_wr);
         chk($sformatf("v%0d_mem", i), mem[vt[i].idx], vt[i].exp_mem);
         chk($sformatf("v%0d_hold", i), hold_err - h0, 0);
         chk($sformatf("v%0d_done", i), done_total - d0, 1);
         if (vt[i].exp_wr != 0) begin
            chk($sformatf("v%0d_we", i), last_we, vt[i].exp_we);
            chk($sformatf("v%0d_din", i), last_din, vt[i].exp_din);
         end
         if (vt[i].exp_nwb != 0) begin
            chk($sformatf("v%0d_wb_way", i), log_way[k0 % 16], vt[i].exp_way0);
            chk($sformatf("v%0d_wb_idx", i), log_idx[k0 % 16], vt[i].idx);
            chk($sformatf("v%0d_wb_tag", i), log_tag[k0 % 16], vt[i].exp_tag0);
            chk($sformatf("v%0d_wb_len", i), log_hold[k0 % 16], vt[i].ack_lat);
         end
      end

      // Both ways dirty at the last set, INV all, zero-wait ack
      clear_mem();
      poke(9'h1FF, {18'h35555, 18'h36666});
      poke(9'h000, {18'h00000, 18'h20042});
      ack_lat = 1;
      @(negedge clk); #1;
      b0 = busy_total; d0 = done_total; w0 = wr_total; k0 = wb_total;
      issue(1'b1, 1'b1, 9'h0);
      wait_done(2200, "last");
      @(negedge clk); #1;
      chk("last_cycles", busy_total - b0, 2050);
      chk("last_nwb", wb_total - k0, 2);
      chk("last_wb0_way", log_way[k0 % 16], 0);
      chk("last_wb0_tag", log_tag[k0 % 16], 16'h6666);
      chk("last_wb0_idx", log_idx[k0 % 16], 9'h1FF);
      chk("last_wb1_way", log_way[(k0 + 1) % 16], 1);
      chk("last_wb1_tag", log_tag[(k0 + 1) % 16], 16'h5555);
      chk("last_mem511", mem[511], 36'h0);
      chk("last_mem0", mem[0], 36'h0);
      repeat (10) @(negedge clk);
      #1;
      chk("last_no_wrap_writes", wr_total - w0, 512);
      chk("last_done_pulses", done_total - d0, 1);
      chk("last_busy_after", busy, 0);

      // Reset while waiting for writeback ack
      poke(9'h040, {18'h00000, 18'h34321});
      ack_lat = 1000;
      @(negedge clk); #1;
      w0 = wr_total; k0 = wb_total;
      issue(1'b0, 1'b0, 9'h040);
      for (int i = 0; i < 20 && !wb_req; i++) begin
         @(negedge clk); #1;
      end
      chk("abort_wb_req_seen", wb_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_wb_req", wb_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_tag_we", tag_we, 0);
      chk("abort_tag_addr", tag_addr, 0);
      chk("abort_wb_fields", {wb_way, wb_index, wb_tag, tag_din}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ack_lat = 1;
      repeat (10) @(negedge clk);
      #1;
      chk("abort_no_write", wr_total - w0, 0);
      chk("abort_no_ack", wb_total - k0, 0);
      chk("abort_mem", mem[9'h040], {18'h00000, 18'h34321});

      // cmd_valid pulsed while busy; stray acks while wb_req is low
      poke(9'h020, {18'h00000, 18'h30F0F});
      ack_lat = 4;
      noise_ack = 1'b1;
      @(negedge clk); #1;
      b0 = busy_total; d0 = done_total;
      issue(1'b0, 1'b0, 9'h020);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); cmd_valid = 1'b1; cmd_inv = 1'b1; cmd_all = 1'b1;
      end
      @(negedge clk); cmd_valid = 1'b0;
      wait_done(60, "busycmd");
      repeat (20) @(negedge clk);
      #1;
      noise_ack = 1'b0;
      chk("busycmd_cycles", busy_total - b0, 8);
      chk("busycmd_done_pulses", done_total - d0, 1);
      chk("busycmd_mem", mem[9'h020], {18'h00000, 18'h20F0F});
      chk("busycmd_busy_after", busy, 0);

`ifdef DCACHE_MAINT_STATS_EN
      clear_mem();
      poke(9'd3,   {18'h00000, 18'h30003});
      poke(9'd100, {18'h30064, 18'h30064});
      poke(9'd200, {18'h300C8, 18'h00000});
      poke(9'd511, {18'h00000, 18'h301FF});
      ack_lat = 2;
      issue(1'b0, 1'b1, 9'h0);
      wait_done(2200, "stats");
      chk("stats_count", wb_count, 5);
      issue(1'b0, 1'b0, 9'd5);
      #1;
      chk("stats_cleared", wb_count, 0);
      wait_done(60, "stats2");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
